// File: rtl/flipflop_i_encoder_reg.sv
// I-flipflop register: binary-encodes one-hot P2 set strobes into a registered
// instruction code, with a one-entry stall buffer and sticky error flags.
module flipflop_i_encoder_reg #(
  parameter int               N_SET      = 256,
  parameter int               CODE_W     = 8,
  parameter logic [CODE_W-1:0] RESET_CODE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SET-1:0]  set_vec,
  input  logic              stall,
  input  logic              clear,
  input  logic              err_clr,
  output logic [CODE_W-1:0] code_q,
  output logic              code_valid,
  output logic              load_pulse,
  output logic              pending,
  output logic              multi_err,
  output logic              overrun_err
);

  generate
    if ((2 ** CODE_W) < N_SET) begin : g_width_check
      $error("flipflop_i_encoder_reg: CODE_W too narrow for N_SET");
    end
  endgenerate

  logic [CODE_W-1:0] enc;
  logic              any_set;
  logic              multi_hot;
  logic [CODE_W-1:0] pend_code;
  logic              overrun_evt;

  // OR-encode rather than priority-encode so multi-hot inputs stay observable.
  always_comb begin
    enc       = '0;
    any_set   = 1'b0;
    multi_hot = 1'b0;
    for (int i = 0; i < N_SET; i++) begin
      if (set_vec[i]) begin
        if (any_set) begin
          multi_hot = 1'b1;
        end
        any_set = 1'b1;
        enc     = enc | CODE_W'(i);
      end
    end
  end

  assign overrun_evt = !clear && stall && any_set && pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q     <= RESET_CODE;
      code_valid <= 1'b0;
      load_pulse <= 1'b0;
      pending    <= 1'b0;
      pend_code  <= '0;
    end else if (clear) begin
      code_q     <= RESET_CODE;
      code_valid <= 1'b0;
      load_pulse <= 1'b0;
      pending    <= 1'b0;
    end else if (!stall) begin
      if (pending) begin
        // Buffered code goes first; a same-cycle strobe takes its place.
        code_q     <= pend_code;
        code_valid <= 1'b1;
        load_pulse <= 1'b1;
        if (any_set) begin
          pend_code <= enc;
        end else begin
          pending <= 1'b0;
        end
      end else if (any_set) begin
        code_q     <= enc;
        code_valid <= 1'b1;
        load_pulse <= 1'b1;
      end else begin
        load_pulse <= 1'b0;
      end
    end else begin
      load_pulse <= 1'b0;
      if (any_set && !pending) begin
        pend_code <= enc;
        pending   <= 1'b1;
      end
    end
  end

  // Sticky flags: a new error in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multi_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      multi_err   <= multi_hot   | (multi_err   & ~err_clr);
      overrun_err <= overrun_evt | (overrun_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_flipflop_i_encoder_reg.sv
// Scoreboard bench for flipflop_i_encoder_reg: loads are predicted into a queue
// and a negedge monitor pops one entry for every load_pulse the DUT produces.
module tb_flipflop_i_encoder_reg;

  logic         clk;
  logic         rst_n;
  logic [255:0] set_vec;
  logic         stall;
  logic         clear;
  logic         err_clr;
  logic [7:0]   code_q;
  logic         code_valid;
  logic         load_pulse;
  logic         pending;
  logic         multi_err;
  logic         overrun_err;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  flipflop_i_encoder_reg dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_vec    (set_vec),
    .stall      (stall),
    .clear      (clear),
    .err_clr    (err_clr),
    .code_q     (code_q),
    .code_valid (code_valid),
    .load_pulse (load_pulse),
    .pending    (pending),
    .multi_err  (multi_err),
    .overrun_err(overrun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] bit_at(input int idx);
    logic [255:0] one;
    one = 256'd1;
    return one << idx;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the negedge, let one rising edge pass, return at the next negedge.
  task automatic apply_stimulus(input logic [255:0] v, input logic st, input logic cl, input logic ec);
    set_vec = v;
    stall   = st;
    clear   = cl;
    err_clr = ec;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: every load must match the oldest predicted code.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && load_pulse === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_load: got code %0h expected no load", code_q);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (code_q !== e) begin
            bad++;
            $display("[TB] FAIL load_code: got %0h expected %0h", code_q, e);
          end
        end
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    set_vec = '0;
    stall   = 1'b0;
    clear   = 1'b0;
    err_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    check_output("rst_code", code_q, 0);
    check_output("rst_valid", code_valid, 0);
    check_output("rst_load", load_pulse, 0);
    check_output("rst_pending", pending, 0);
    check_output("rst_errs", {multi_err, overrun_err}, 0);

    // Single strobe
    exp_q.push_back(8'h47);
    apply_stimulus(bit_at(8'h47), 0, 0, 0);
    check_output("single_valid", code_valid, 1);
    check_output("single_load", load_pulse, 1);
    apply_stimulus('0, 0, 0, 0);
    check_output("single_pulse_end", load_pulse, 0);
    check_output("single_hold", code_q, 8'h47);

    // Asynchronous reset in mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_code", code_q, 0);
    check_output("async_rst_valid", code_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back loads
    exp_q.push_back(8'h60);
    apply_stimulus(bit_at(8'h60), 0, 0, 0);
    check_output("b2b_load0", load_pulse, 1);
    exp_q.push_back(8'h61);
    apply_stimulus(bit_at(8'h61), 0, 0, 0);
    check_output("b2b_load1", load_pulse, 1);
    exp_q.push_back(8'hF0);
    apply_stimulus(bit_at(8'hF0), 0, 0, 0);
    check_output("b2b_load2", load_pulse, 1);
    apply_stimulus('0, 0, 0, 0);
    check_output("b2b_idle", load_pulse, 0);

    // Stall buffering and overrun
    apply_stimulus(bit_at(8'hC8), 1, 0, 0);
    check_output("stall_pending", pending, 1);
    check_output("stall_code_hold", code_q, 8'hF0);
    check_output("stall_no_load", load_pulse, 0);
    apply_stimulus(bit_at(8'hD8), 1, 0, 0);
    check_output("overrun_flag", overrun_err, 1);
    check_output("overrun_pending", pending, 1);
    exp_q.push_back(8'hC8);
    apply_stimulus('0, 0, 0, 0);
    check_output("drain_pending", pending, 0);
    check_output("drain_load", load_pulse, 1);
    apply_stimulus('0, 0, 0, 1);
    check_output("overrun_cleared", overrun_err, 0);

    // Stall release with a simultaneous strobe
    apply_stimulus(bit_at(8'h48), 1, 0, 0);
    check_output("rel_pending0", pending, 1);
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h58);
    apply_stimulus(bit_at(8'h58), 0, 0, 0);
    check_output("rel_pending1", pending, 1);
    check_output("rel_load1", load_pulse, 1);
    apply_stimulus('0, 0, 0, 0);
    check_output("rel_pending2", pending, 0);
    check_output("rel_load2", load_pulse, 1);
    apply_stimulus('0, 0, 0, 0);
    check_output("rel_idle", load_pulse, 0);

    // Multi-hot encodes as OR; set beats err_clr
    exp_q.push_back(8'h03);
    apply_stimulus(bit_at(1) | bit_at(2), 0, 0, 0);
    check_output("multi_set", multi_err, 1);
    exp_q.push_back(8'h0F);
    apply_stimulus(bit_at(5) | bit_at(10), 0, 0, 1);
    check_output("multi_set_wins", multi_err, 1);
    apply_stimulus('0, 0, 0, 1);
    check_output("multi_cleared", multi_err, 0);

    // Clear beats capture and overrun
    apply_stimulus(bit_at(8'h30), 1, 0, 0);
    check_output("clr_pending_pre", pending, 1);
    apply_stimulus(bit_at(8'h4F), 1, 1, 0);
    check_output("clr_code", code_q, 0);
    check_output("clr_valid", code_valid, 0);
    check_output("clr_pending", pending, 0);
    check_output("clr_load", load_pulse, 0);
    check_output("clr_no_overrun", overrun_err, 0);
    apply_stimulus('0, 0, 0, 0);
    check_output("clr_after_valid", code_valid, 0);
    check_output("clr_after_pending", pending, 0);

    // Multi-hot still flagged under clear, nothing loaded
    apply_stimulus(bit_at(3) | bit_at(4), 0, 1, 0);
    check_output("clr_multi", multi_err, 1);
    check_output("clr_multi_valid", code_valid, 0);
    apply_stimulus('0, 0, 0, 0);
    apply_stimulus('0, 0, 0, 0);

    check_output("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
